// File: rtl/instruction_fetch.sv
// Fetch stage feeding the RV32I datapath: PC sequencing, credit-limited memory
// requests, an in-order instruction queue and redirect/flush on taken branches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] return_address,
  input  logic        inst_ready,
  input  logic        beq,
  input  logic        bneq,
  input  logic        bge,
  input  logic        blt,
  input  logic        jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        addr_misaligned
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW:0]     LP_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic {S_FETCH, S_FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_misaligned;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  logic          w_redirect;
  logic [31:0]   w_target_raw;
  logic [31:0]   w_target;
  logic          w_credit_ok;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_drop_next;
  logic [31:0]   w_head_pc;

  assign w_redirect   = jump | beq | bneq | bge | blt;
  assign w_target_raw = jump ? jump_target : branch_target;
  assign w_target     = {w_target_raw[31:2], 2'b00};

  // Credits count both queued and in-flight words, so every response has a slot.
  assign w_credit_ok  = ({1'b0, r_count} + {1'b0, r_outstanding}) < LP_DEPTH;
  assign w_req_valid  = !rst && (r_state == S_FETCH) && !halt && !w_redirect && w_credit_ok;
  assign w_req_fire   = w_req_valid && imem_req_ready;
  assign w_pop        = inst_valid && inst_ready;
  assign w_push       = imem_resp_valid && (r_state == S_FETCH) && !w_redirect;
  assign w_drop_next  = r_outstanding - CW'(imem_resp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned  <= w_redirect && (w_target_raw[1:0] != 2'b00);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      case (r_state)
        S_FETCH: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= w_drop_next;
            r_state    <= (w_drop_next != '0) ? S_FLUSH : S_FETCH;
          end else begin
            if (w_push) begin
              r_wr_ptr  <= r_wr_ptr + 1'b1;
              r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
          end
        end
        S_FLUSH: begin
          // Queue is already empty here; only the stale in-flight words remain.
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
          end
          if (imem_resp_valid) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
            if (r_drop_cnt == CW'(1)) begin
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_resp_data;
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  assign w_head_pc       = r_q_pc[r_rd_ptr];
  assign inst_valid      = (r_count != '0);
  assign inst            = inst_valid ? r_q_inst[r_rd_ptr] : 32'd0;
  assign inst_pc         = inst_valid ? w_head_pc : 32'd0;
  assign return_address  = inst_valid ? (w_head_pc + 32'd4) : 32'd0;
  assign imem_req_valid  = w_req_valid;
  assign imem_req_addr   = r_fetch_pc;
  assign addr_misaligned = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory with programmable latency and
// a scoreboard of expected PCs, cleared whenever the bench issues a redirect.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] return_address;
  logic        inst_ready = 1'b1;
  logic        beq = 1'b0, bneq = 1'b0, bge = 1'b0, blt = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] jump_target = 32'd0;
  logic        halt = 1'b0;
  logic        addr_misaligned;

  instruction_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .return_address(return_address), .inst_ready(inst_ready),
    .beq(beq), .bneq(bneq), .bge(bge), .blt(blt), .jump(jump),
    .branch_target(branch_target), .jump_target(jump_target),
    .halt(halt), .addr_misaligned(addr_misaligned)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_req = 0;
  int          n_pop = 0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] last_pop_pc = 32'd0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive memory response, account for handshakes, advance to next negedge.
  task automatic cycle();
    logic hs, rsp, pop, redir;
    logic [31:0] e;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
    end
    #1;
    hs    = imem_req_valid && imem_req_ready;
    rsp   = imem_resp_valid;
    pop   = inst_valid && inst_ready;
    redir = jump | beq | bneq | bge | blt;
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {31'd0, pop}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst", inst, mem_word(e));
        check("return_address", return_address, e + 32'd4);
        last_pop_pc = inst_pc;
      end
      n_pop++;
    end
    if (redir) begin
      check("req_in_redirect", {31'd0, imem_req_valid}, 32'd0);
      exp_q.delete();
      exp_fetch = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    end
    if (hs) begin
      check("req_addr", imem_req_addr, exp_fetch);
      exp_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(cyc + lat);
      n_req++;
    end
    if (rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    {jump, beq, bneq, bge, blt} = 5'd0;
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_return_address", return_address, 32'd0);
    check("rst_misaligned", {31'd0, addr_misaligned}, 32'd0);
    mem_addr.delete();
    mem_due.delete();
    exp_q.delete();
    exp_fetch = RST_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pending3(input string tag);
    logic ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (mem_addr.size() == 3 && inst_valid) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_pop(input string tag);
    int n0 = n_pop;
    for (int k = 0; k < 40 && n_pop == n0; k++) cycle();
    check(tag, {31'd0, (n_pop != n0)}, 32'd1);
  endtask

  initial begin
    int n0;
    logic ok;
    @(negedge clk);
    do_reset();

    // Back-pressure from reset: credits cap in-flight work at four words.
    inst_ready = 1'b0;
    lat = 1;
    n_req = 0;
    repeat (10) cycle();
    check("credit_requests", n_req, 32'd4);
    check("credit_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("full_head_pc", inst_pc, RST_PC);
    inst_ready = 1'b1;
    #1;
    check("pop_cycle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    check("after_pop_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Streaming at latency 1 delivers one word per cycle.
    repeat (10) cycle();
    n0 = n_pop;
    repeat (10) cycle();
    check("no_gap_stream", n_pop - n0, 32'd10);
    halt = 1'b1;
    #1;
    check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    halt = 1'b0;
    repeat (4) cycle();

    // Branch with three words in flight at latency 3.
    do_reset();
    lat = 3;
    wait_pending3("wait_pending_beq");
    beq = 1'b1;
    branch_target = 32'h0000_0200;
    cycle();
    beq = 1'b0;
    #1;
    check("beq_queue_empty", {31'd0, inst_valid}, 32'd0);
    check("beq_flush_req_valid", {31'd0, imem_req_valid}, 32'd0);
    wait_pop("beq_first_pop");
    check("beq_first_pc", last_pop_pc, 32'h0000_0200);
    repeat (6) cycle();

    // Jump and branch together, with a response landing in the same cycle.
    lat = 1;
    repeat (8) cycle();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    check("wait_resp_for_jump", {31'd0, ok}, 32'd1);
    jump = 1'b1;
    jump_target = 32'h0000_0300;
    bneq = 1'b1;
    branch_target = 32'h0000_0400;
    cycle();
    jump = 1'b0;
    bneq = 1'b0;
    #1;
    check("jump_fetch_pc", imem_req_addr, 32'h0000_0300);
    wait_pop("jump_first_pop");
    check("jump_first_pc", last_pop_pc, 32'h0000_0300);
    repeat (6) cycle();

    // Misaligned jump target.
    jump = 1'b1;
    jump_target = 32'h0000_0302;
    #1;
    check("misaligned_before", {31'd0, addr_misaligned}, 32'd0);
    cycle();
    jump = 1'b0;
    #1;
    check("misaligned_pulse", {31'd0, addr_misaligned}, 32'd1);
    check("misaligned_fetch_pc", imem_req_addr, 32'h0000_0300);
    cycle();
    check("misaligned_cleared", {31'd0, addr_misaligned}, 32'd0);
    wait_pop("misaligned_first_pop");
    check("misaligned_first_pc", last_pop_pc, 32'h0000_0300);
    repeat (4) cycle();

    // Asynchronous reset during a flush with two words still outstanding.
    lat = 3;
    wait_pending3("wait_pending_rst");
    jump = 1'b1;
    jump_target = 32'h0000_0333;
    cycle();
    jump = 1'b0;
    #1;
    check("pre_rst_misaligned", {31'd0, addr_misaligned}, 32'd1);
    check("pre_rst_outstanding", mem_addr.size(), 32'd2);
    do_reset();
    n0 = n_req;
    for (int k = 0; k < 10 && n_req == n0; k++) cycle();
    check("restart_request", {31'd0, (n_req != n0)}, 32'd1);
    wait_pop("restart_first_pop");
    check("restart_first_pc", last_pop_pc, RST_PC);
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
